tone_gen: RTL and testbench



---
 rtl/tone_pkg.sv | 40 ++++
 rtl/tone_lut.sv | 58 +++++
 rtl/tone_gen.sv | 140 ++++++++++++++
 tb/tb_tone_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants, note-code helpers and FSM state type for the tone generator.
package tone_pkg;

  localparam logic [5:0] NOTE_REST = 6'd63;
  localparam logic [5:0] NOTE_GAP  = 6'd10;
  localparam logic [5:0] NOTE_MIN  = 6'd12;
  localparam logic [5:0] NOTE_MAX  = 6'd62;

  // A3..G#4 equal-tempered frequencies in millihertz; index 0 is A3 (220 Hz).
  localparam logic [11:0][19:0] F_MHZ = {
    20'd415305,  // G#4
    20'd391995,  // G4
    20'd369994,  // F#4
    20'd349228,  // F4
    20'd329628,  // E4
    20'd311127,  // D#4
    20'd293665,  // D4
    20'd277183,  // C#4
    20'd261626,  // C4
    20'd246942,  // B3
    20'd233082,  // A#3
    20'd220000   // A3
  };

  typedef enum logic {
    ST_IDLE,
    ST_SOUND
  } tone_state_e;

  // Base-octave half-period in clk cycles, truncated.
  function automatic longint unsigned base_hp(input logic [3:0] k,
                                              input longint unsigned clk_hz);
    return (clk_hz * 64'd1000) / (64'd2 * 64'(F_MHZ[k]));
  endfunction

  function automatic logic is_rest(input logic [5:0] code);
    return (code == NOTE_GAP) || (code < NOTE_MIN) || (code > NOTE_MAX);
  endfunction

endpackage

// File: rtl/tone_lut.sv
// Registers the incoming note code and maps it to a half-period and rest flag.
module tone_lut
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [5:0]       code_i,
  output logic [5:0]       code_o,
  output logic [CNT_W-1:0] hp_o,
  output logic             rest_o
);

  logic [CNT_W-1:0] base_tbl [12];

  for (genvar k = 0; k < 12; k++) begin : g_base
    localparam longint unsigned HP = base_hp(4'(k), 64'(CLK_HZ));
    assign base_tbl[k] = HP[CNT_W-1:0];
  end

  logic [5:0] code_q, code_d;

  always_comb begin
    code_d = en_i ? code_i : NOTE_REST;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= NOTE_REST;
    end else begin
      code_q <= code_d;
    end
  end

  logic [5:0] rel;
  logic [2:0] oct;
  logic [3:0] semi;

  // NOTE: every signal driven here is given a value on every path, so no
  // latches are inferred.
  always_comb begin
    rel    = code_q - NOTE_MIN;
    oct    = 3'(rel / 6'd12);
    semi   = 4'(rel % 6'd12);
    rest_o = is_rest(code_q);
    code_o = code_q;
    hp_o   = '0;
    if (!rest_o) begin
      hp_o = base_tbl[semi] >> oct;
    end
  end

endmodule

// File: rtl/tone_gen.sv
// Note-code to square-wave buzzer driver; note changes take effect only on half-period
// boundaries. Define TONE_PWM_EN to add a 4-bit vol input that PWM-gates the tone.
module tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] note,
`ifdef TONE_PWM_EN
  input  logic [3:0] vol,
`endif
  output logic       buzz,
  output logic       active,
  output logic [5:0] cur_note
);

  logic [5:0]       lut_code;
  logic [CNT_W-1:0] lut_hp;
  logic             lut_rest;

  tone_lut #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .code_i (note),
    .code_o (lut_code),
    .hp_o   (lut_hp),
    .rest_o (lut_rest)
  );

  tone_state_e      state_q, state_d;
  logic             tone_q, tone_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       cur_q, cur_d;
  logic [5:0]       pend_code_q, pend_code_d;
  logic [CNT_W-1:0] pend_hp_q, pend_hp_d;
  logic             pend_rest_q, pend_rest_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tone_q      <= 1'b0;
      cnt_q       <= '0;
      cur_q       <= NOTE_REST;
      pend_code_q <= NOTE_REST;
      pend_hp_q   <= '0;
      pend_rest_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tone_q      <= tone_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      pend_code_q <= pend_code_d;
      pend_hp_q   <= pend_hp_d;
      pend_rest_q <= pend_rest_d;
    end
  end

  // The pending slot always tracks the latest lookup; only the counter
  // boundary (or an idle start) commits it to the output.
  always_comb begin
    state_d     = state_q;
    tone_d      = tone_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    pend_code_d = lut_code;
    pend_hp_d   = lut_hp;
    pend_rest_d = lut_rest;

    if (!en) begin
      state_d     = ST_IDLE;
      tone_d      = 1'b0;
      cnt_d       = '0;
      cur_d       = NOTE_REST;
      pend_code_d = NOTE_REST;
      pend_hp_d   = '0;
      pend_rest_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!pend_rest_q) begin
            state_d = ST_SOUND;
            tone_d  = 1'b1;
            cnt_d   = pend_hp_q - CNT_W'(1);
            cur_d   = pend_code_q;
          end
        end
        ST_SOUND: begin
          if (cnt_q == '0) begin
            if (pend_rest_q) begin
              state_d = ST_IDLE;
              tone_d  = 1'b0;
              cnt_d   = '0;
              cur_d   = NOTE_REST;
            end else begin
              tone_d = ~tone_q;
              cnt_d  = pend_hp_q - CNT_W'(1);
              cur_d  = pend_code_q;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          tone_d  = 1'b0;
          cnt_d   = '0;
          cur_d   = NOTE_REST;
        end
      endcase
    end
  end

  assign active   = (state_q == ST_SOUND);
  assign cur_note = cur_q;

`ifdef TONE_PWM_EN
  logic [3:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
    end
  end

  assign buzz = tone_q & ((vol == 4'd15) | (pwm_cnt_q < vol));
`else
  assign buzz = tone_q;
`endif

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen at CLK_HZ = 1 MHz; expected half-periods are hand-computed.
module tb_tone_gen;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned CNT_W  = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [5:0] note;
`ifdef TONE_PWM_EN
  logic [3:0] vol;
`endif
  logic       buzz;
  logic       active;
  logic [5:0] cur_note;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tone_gen #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .note     (note),
`ifdef TONE_PWM_EN
    .vol      (vol),
`endif
    .buzz     (buzz),
    .active   (active),
    .cur_note (cur_note)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until buzz reaches lvl; -1 if it never does within the budget.
  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    while (buzz !== lvl && n < 5000) begin
      step(1);
      n++;
    end
    if (buzz !== lvl) n = -1;
  endtask

  int  n;
  int  m;
  int  ones;
  logic seen_high;

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    note  = 6'd63;
`ifdef TONE_PWM_EN
    vol   = 4'd15;
`endif
    #2 rst_n = 1'b0;
    step(3);
    check("reset_buzz", 32'(buzz), 32'd0);
    check("reset_active", 32'(active), 32'd0);
    check("reset_cur_note", 32'(cur_note), 32'd63);

    // A4 from idle: first rise three edges after the note is applied.
    rst_n = 1'b1;
    step(2);
    en   = 1'b1;
    note = 6'd24;
    wait_level(1'b1, n);
    check("a4_start_latency", 32'(n), 32'd3);
    check("a4_active", 32'(active), 32'd1);
    check("a4_cur_note", 32'(cur_note), 32'd24);
    wait_level(1'b0, n);
    check("a4_high", 32'(n), 32'd1136);
    wait_level(1'b1, n);
    check("a4_low", 32'(n), 32'd1136);

    // 24 -> 15 mid high phase: the current half completes first.
    step(500);
    note = 6'd15;
    wait_level(1'b0, m);
    check("c4_switch_high", 32'(500 + m), 32'd1136);
    check("c4_cur_note", 32'(cur_note), 32'd15);
    wait_level(1'b1, n);
    check("c4_low", 32'(n), 32'd1911);
    wait_level(1'b0, n);
    check("c4_high", 32'(n), 32'd1911);

    // 15 -> 36 while low.
    note = 6'd36;
    wait_level(1'b1, n);
    check("a5_switch_low", 32'(n), 32'd1911);
    wait_level(1'b0, n);
    check("a5_high", 32'(n), 32'd568);
    wait_level(1'b1, n);
    check("a5_low", 32'(n), 32'd568);

    // Lowest pitched code.
    note = 6'd12;
    wait_level(1'b0, n);
    check("a3_switch_high", 32'(n), 32'd568);
    wait_level(1'b1, n);
    check("a3_low", 32'(n), 32'd2272);

    // Highest pitched code: BASE_HP[2] = 2024, >> 4 = 126.
    note = 6'd62;
    wait_level(1'b0, n);
    check("b7_switch_high", 32'(n), 32'd2272);
    wait_level(1'b1, n);
    check("b7_low", 32'(n), 32'd126);
    check("b7_cur_note", 32'(cur_note), 32'd62);
    wait_level(1'b0, n);
    check("b7_high", 32'(n), 32'd126);

    // Back to A4, then a rest while high.
    note = 6'd24;
    wait_level(1'b1, n);
    check("a4_again_low", 32'(n), 32'd126);
    step(100);
    note = 6'd63;
    wait_level(1'b0, m);
    check("rest_fall", 32'(100 + m), 32'd1136);
    check("rest_active", 32'(active), 32'd0);
    check("rest_cur_note", 32'(cur_note), 32'd63);
    seen_high = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (buzz !== 1'b0) seen_high = 1'b1;
    end
    check("rest_silent", 32'(seen_high), 32'd0);
    check("rest_still_idle", 32'(active), 32'd0);

    // 24 -> 10 -> 24 inside one half-period: no gap.
    note = 6'd24;
    wait_level(1'b1, n);
    check("restart_latency", 32'(n), 32'd3);
    step(200);
    note = 6'd10;
    step(300);
    note = 6'd24;
    wait_level(1'b0, m);
    check("gap_high", 32'(500 + m), 32'd1136);
    check("gap_active", 32'(active), 32'd1);
    wait_level(1'b1, n);
    check("gap_low", 32'(n), 32'd1136);
    check("gap_cur_note", 32'(cur_note), 32'd24);

`ifdef TONE_PWM_EN
    vol  = 4'd4;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (buzz === 1'b1) ones++;
    end
    check("pwm_vol4", 32'(ones), 32'd4);
    vol  = 4'd0;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (buzz === 1'b1) ones++;
    end
    check("pwm_vol0", 32'(ones), 32'd0);
    check("pwm_vol0_active", 32'(active), 32'd1);
    vol  = 4'd15;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (buzz === 1'b1) ones++;
    end
    check("pwm_vol15", 32'(ones), 32'd16);
`endif

    // Enable dropped mid-note clears on the next edge and ignores input.
    step(100);
    en = 1'b0;
    step(1);
    check("en_off_buzz", 32'(buzz), 32'd0);
    check("en_off_active", 32'(active), 32'd0);
    check("en_off_cur_note", 32'(cur_note), 32'd63);
    step(10);
    check("en_off_ignored", 32'(active), 32'd0);
    en = 1'b1;
    wait_level(1'b1, n);
    check("en_on_latency", 32'(n), 32'd3);

    // Asynchronous reset mid-note takes effect before the next edge.
    step(50);
    rst_n = 1'b0;
    #2;
    check("async_rst_buzz", 32'(buzz), 32'd0);
    check("async_rst_active", 32'(active), 32'd0);
    check("async_rst_cur_note", 32'(cur_note), 32'd63);
    step(2);
    rst_n = 1'b1;
    wait_level(1'b1, n);
    check("post_rst_latency", 32'(n), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
